// File: rtl/stim_train_sequencer_if.sv
// Config, control and drive bundle between the stim register block, the sequencer and the DAC/switch driver.
// The master modport belongs to the register/control side and the slave modport belongs to the sequencer.
interface stim_train_sequencer_if #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 16,
    parameter int MAG_W  = 8
);
    logic [CNT_W-1:0]  cfg_pulse_length;
    logic [CNT_W-1:0]  cfg_interphase;
    logic [CNT_W-1:0]  cfg_inter_bipulse;
    logic [CNT_W-1:0]  cfg_inter_train;
    logic [CNT_W-1:0]  cfg_bipulses;
    logic [CNT_W-1:0]  cfg_trains;
    logic [CNT_W-1:0]  cfg_recovery;
    logic [MAG_W-1:0]  cfg_magnitude;
    logic              cfg_ramp_en;
    logic [MAG_W-1:0]  cfg_ramp_step;
    logic              cfg_pos_first;
    logic              cfg_bipolar;
    logic [NUM_CH-1:0] cfg_mask_pos;
    logic [NUM_CH-1:0] cfg_mask_neg;
    logic              start_finite;
    logic              start_infinite;
    logic              stop_infinite;
    logic              abort;
    logic              stim_en;
    logic [MAG_W-1:0]  stim_mag;
    logic [NUM_CH-1:0] drive_src;
    logic [NUM_CH-1:0] drive_sink;
    logic [NUM_CH-1:0] recovery_en;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  train_idx;
    logic [CNT_W-1:0]  bipulse_idx;

    modport master (
        output cfg_pulse_length, cfg_interphase, cfg_inter_bipulse, cfg_inter_train,
               cfg_bipulses, cfg_trains, cfg_recovery, cfg_magnitude, cfg_ramp_en,
               cfg_ramp_step, cfg_pos_first, cfg_bipolar, cfg_mask_pos, cfg_mask_neg,
               start_finite, start_infinite, stop_infinite, abort,
        input  stim_en, stim_mag, drive_src, drive_sink, recovery_en, busy, done,
               train_idx, bipulse_idx
    );

    modport slave (
        input  cfg_pulse_length, cfg_interphase, cfg_inter_bipulse, cfg_inter_train,
               cfg_bipulses, cfg_trains, cfg_recovery, cfg_magnitude, cfg_ramp_en,
               cfg_ramp_step, cfg_pos_first, cfg_bipolar, cfg_mask_pos, cfg_mask_neg,
               start_finite, start_infinite, stop_infinite, abort,
        output stim_en, stim_mag, drive_src, drive_sink, recovery_en, busy, done,
               train_idx, bipulse_idx
    );
endinterface

// File: rtl/stim_train_sequencer.sv
// Biphasic pulse-train sequencer with per-train ramp, graceful stop and abort into charge recovery.
// Latency: a start sampled at edge k shows PHASE_A from cycle k+1; all outputs are registered; backpressure: none.
module stim_train_sequencer #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 16,
    parameter int MAG_W  = 8
) (
    input  logic                  clk,
    input  logic                  rstn,
    stim_train_sequencer_if.slave bus
);
    localparam int PW = MAG_W + CNT_W + 1;

    typedef enum logic [2:0] {
        IDLE, PHASE_A, GAP_IP, PHASE_B, GAP_BP, GAP_TR, RECOVERY, SKIP
    } state_t;

    typedef struct packed {
        logic [CNT_W-1:0]  pulse_length;
        logic [CNT_W-1:0]  interphase;
        logic [CNT_W-1:0]  inter_bipulse;
        logic [CNT_W-1:0]  inter_train;
        logic [CNT_W-1:0]  bipulses;
        logic [CNT_W-1:0]  trains;
        logic [CNT_W-1:0]  recovery;
        logic [MAG_W-1:0]  magnitude;
        logic [MAG_W-1:0]  ramp_step;
        logic              ramp_en;
        logic              pos_first;
        logic              bipolar;
        logic [NUM_CH-1:0] mask_pos;
        logic [NUM_CH-1:0] mask_neg;
    } cfg_t;

    state_t            state, state_d;
    cfg_t              cfg_q, cfg_d, cfg_in;
    logic [CNT_W-1:0]  cnt, cnt_d, bp_q, bp_d, tr_q, tr_d, len_m1;
    logic [CNT_W:0]    bp_inc, tr_inc, tr_d1;
    logic              stop_q, stop_d, inf_q, inf_d, to_rec;
    logic              phase_d, pos_d;
    logic [PW-1:0]     ramp_prod;
    logic [MAG_W-1:0]  mag_d;
    logic [NUM_CH-1:0] ret_d, src_d, sink_d;
    logic              stim_en_q, busy_q, done_q;
    logic [MAG_W-1:0]  mag_q;
    logic [NUM_CH-1:0] src_q, sink_q, rec_q;

    function automatic logic [CNT_W-1:0] dec_sat(input logic [CNT_W-1:0] x);
        return (x == '0) ? '0 : x - CNT_W'(1);
    endfunction

    assign cfg_in = '{
        pulse_length:  bus.cfg_pulse_length,  interphase: bus.cfg_interphase,
        inter_bipulse: bus.cfg_inter_bipulse, inter_train: bus.cfg_inter_train,
        bipulses:      bus.cfg_bipulses,      trains:      bus.cfg_trains,
        recovery:      bus.cfg_recovery,      magnitude:   bus.cfg_magnitude,
        ramp_step:     bus.cfg_ramp_step,     ramp_en:     bus.cfg_ramp_en,
        pos_first:     bus.cfg_pos_first,     bipolar:     bus.cfg_bipolar,
        mask_pos:      bus.cfg_mask_pos,      mask_neg:    bus.cfg_mask_neg
    };

    assign len_m1 = dec_sat(cfg_q.pulse_length);
    assign bp_inc = {1'b0, bp_q} + (CNT_W+1)'(1);
    assign tr_inc = {1'b0, tr_q} + (CNT_W+1)'(1);

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        bp_d    = bp_q;
        tr_d    = tr_q;
        stop_d  = stop_q;
        inf_d   = inf_q;
        cfg_d   = cfg_q;
        to_rec  = 1'b0;
        case (state)
            IDLE: begin
                if (!bus.abort && (bus.start_finite || bus.start_infinite)) begin
                    cfg_d  = cfg_in;
                    inf_d  = !bus.start_finite;
                    stop_d = 1'b0;
                    bp_d   = '0;
                    tr_d   = '0;
                    // Empty run: one busy cycle, no phases and no recovery.
                    if (cfg_in.bipulses == '0 || (bus.start_finite && cfg_in.trains == '0)) begin
                        state_d = SKIP;
                    end else begin
                        state_d = PHASE_A;
                        cnt_d   = dec_sat(cfg_in.pulse_length);
                    end
                end
            end
            SKIP: state_d = IDLE;
            RECOVERY: begin
                if (cnt == '0) state_d = IDLE;
                else           cnt_d   = cnt - CNT_W'(1);
            end
            default: begin
                if (bus.abort) begin
                    to_rec = 1'b1;
                end else begin
                    if (bus.stop_infinite && inf_q) stop_d = 1'b1;
                    if (cnt != '0) begin
                        cnt_d = cnt - CNT_W'(1);
                    end else begin
                        case (state)
                            PHASE_A: begin
                                if (cfg_q.interphase != '0) begin
                                    state_d = GAP_IP;
                                    cnt_d   = cfg_q.interphase - CNT_W'(1);
                                end else begin
                                    state_d = PHASE_B;
                                    cnt_d   = len_m1;
                                end
                            end
                            GAP_IP: begin
                                state_d = PHASE_B;
                                cnt_d   = len_m1;
                            end
                            PHASE_B: begin
                                if (stop_d) begin
                                    to_rec = 1'b1;
                                end else if (bp_inc < {1'b0, cfg_q.bipulses}) begin
                                    bp_d = bp_inc[CNT_W-1:0];
                                    if (cfg_q.inter_bipulse != '0) begin
                                        state_d = GAP_BP;
                                        cnt_d   = cfg_q.inter_bipulse - CNT_W'(1);
                                    end else begin
                                        state_d = PHASE_A;
                                        cnt_d   = len_m1;
                                    end
                                end else if (inf_q || tr_inc < {1'b0, cfg_q.trains}) begin
                                    bp_d = '0;
                                    // Train index saturates instead of wrapping in infinite mode.
                                    tr_d = tr_inc[CNT_W] ? tr_q : tr_inc[CNT_W-1:0];
                                    if (cfg_q.inter_train != '0) begin
                                        state_d = GAP_TR;
                                        cnt_d   = cfg_q.inter_train - CNT_W'(1);
                                    end else begin
                                        state_d = PHASE_A;
                                        cnt_d   = len_m1;
                                    end
                                end else begin
                                    to_rec = 1'b1;
                                end
                            end
                            default: begin
                                state_d = PHASE_A;
                                cnt_d   = len_m1;
                            end
                        endcase
                    end
                end
            end
        endcase
        if (to_rec) begin
            if (cfg_q.recovery != '0) begin
                state_d = RECOVERY;
                cnt_d   = cfg_q.recovery - CNT_W'(1);
            end else begin
                state_d = IDLE;
            end
        end
    end

    // Output values are derived from the next state so they register alongside it.
    assign tr_d1     = {1'b0, tr_d} + (CNT_W+1)'(1);
    assign ramp_prod = PW'(cfg_d.ramp_step) * PW'(tr_d1);
    assign mag_d     = (!cfg_d.ramp_en || cfg_d.ramp_step == '0 || ramp_prod >= PW'(cfg_d.magnitude))
                       ? cfg_d.magnitude : ramp_prod[MAG_W-1:0];
    assign phase_d   = (state_d == PHASE_A) || (state_d == PHASE_B);
    assign pos_d     = ((state_d == PHASE_A) == cfg_d.pos_first);
    assign ret_d     = cfg_d.bipolar ? cfg_d.mask_neg : '0;
    assign src_d     = !phase_d ? '0 : (pos_d ? cfg_d.mask_pos : ret_d);
    assign sink_d    = !phase_d ? '0 : (pos_d ? ret_d : cfg_d.mask_pos);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            bp_q      <= '0;
            tr_q      <= '0;
            stop_q    <= 1'b0;
            inf_q     <= 1'b0;
            cfg_q     <= '0;
            stim_en_q <= 1'b0;
            mag_q     <= '0;
            src_q     <= '0;
            sink_q    <= '0;
            rec_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state     <= state_d;
            cnt       <= cnt_d;
            bp_q      <= bp_d;
            tr_q      <= tr_d;
            stop_q    <= stop_d;
            inf_q     <= inf_d;
            cfg_q     <= cfg_d;
            stim_en_q <= phase_d;
            mag_q     <= phase_d ? mag_d : '0;
            src_q     <= src_d;
            sink_q    <= sink_d;
            rec_q     <= (state_d == RECOVERY) ? (cfg_d.mask_pos | cfg_d.mask_neg) : '0;
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == IDLE) && (state != IDLE);
        end
    end

    assign bus.stim_en     = stim_en_q;
    assign bus.stim_mag    = mag_q;
    assign bus.drive_src   = src_q;
    assign bus.drive_sink  = sink_q;
    assign bus.recovery_en = rec_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.train_idx   = tr_q;
    assign bus.bipulse_idx = bp_q;
endmodule

// File: tb/tb_stim_train_sequencer.sv
// Directed bench for stim_train_sequencer: finite, ramp, infinite stop, abort, reset and edge-case runs.
module tb_stim_train_sequencer;
    localparam int NUM_CH = 16;
    localparam int CNT_W  = 16;
    localparam int MAG_W  = 8;
    localparam logic [15:0] MP = 16'h00F0;
    localparam logic [15:0] MN = 16'h0F00;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    stim_train_sequencer_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .MAG_W(MAG_W)) bus ();
    stim_train_sequencer #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .MAG_W(MAG_W)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    int chk_n = 0, pass_n = 0, fail_n = 0;
    int busy_n, en_n, phase_n, done_n, rec_n, rec_bad, phase_err, gap_before_rec, timed_out;
    logic [15:0] rec_val;
    logic [15:0] ph_src [64];
    logic [15:0] ph_sink[64];
    logic [7:0]  ph_mag [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        chk_n++;
        assert (obs === exp) pass_n++;
        else begin
            fail_n++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input int len, ip, bp, tr, nbp, ntr, rec, mag,
                           input bit ramp, input int step, input bit posf, bip);
        bus.cfg_pulse_length  = 16'(len);
        bus.cfg_interphase    = 16'(ip);
        bus.cfg_inter_bipulse = 16'(bp);
        bus.cfg_inter_train   = 16'(tr);
        bus.cfg_bipulses      = 16'(nbp);
        bus.cfg_trains        = 16'(ntr);
        bus.cfg_recovery      = 16'(rec);
        bus.cfg_magnitude     = 8'(mag);
        bus.cfg_ramp_en       = ramp;
        bus.cfg_ramp_step     = 8'(step);
        bus.cfg_pos_first     = posf;
        bus.cfg_bipolar       = bip;
        bus.cfg_mask_pos      = MP;
        bus.cfg_mask_neg      = MN;
    endtask

    task automatic start_run(input bit fin, input bit inf);
        bus.start_finite   = fin;
        bus.start_infinite = inf;
        @(negedge clk);
        bus.start_finite   = 1'b0;
        bus.start_infinite = 1'b0;
    endtask

    // Samples on falling edges from the first post-start cycle until two cycles after done.
    task automatic watch(input int max_cyc, input int stop_ph, input int abort_cyc, input int start_cyc);
        logic        prev_en = 1'b0;
        logic [15:0] prev_src = '0, prev_sink = '0, e_src, e_sink;
        int          tail = 0, post = 0, t, prod, e_mag;
        bit          seen_done = 0, seen_rec = 0, pos;
        busy_n = 0; en_n = 0; phase_n = 0; done_n = 0; rec_n = 0; rec_bad = 0;
        phase_err = 0; gap_before_rec = -1; rec_val = '0;
        for (int c = 0; c < max_cyc; c++) begin
            bus.stop_infinite = 1'b0;
            bus.abort         = 1'b0;
            bus.start_finite  = 1'b0;
            if (bus.busy) busy_n++;
            if (bus.done) done_n++;
            if (bus.stim_en) begin
                en_n++;
                tail = 0;
                if (!prev_en || bus.drive_src != prev_src || bus.drive_sink != prev_sink) begin
                    pos    = ((phase_n % 2) == 0) == bus.cfg_pos_first;
                    e_src  = pos ? MP : (bus.cfg_bipolar ? MN : 16'h0);
                    e_sink = pos ? (bus.cfg_bipolar ? MN : 16'h0) : MP;
                    t      = phase_n / (2 * int'(bus.cfg_bipulses));
                    prod   = int'(bus.cfg_ramp_step) * (t + 1);
                    e_mag  = (!bus.cfg_ramp_en || bus.cfg_ramp_step == 0 || prod >= int'(bus.cfg_magnitude))
                             ? int'(bus.cfg_magnitude) : prod;
                    if (bus.drive_src != e_src || bus.drive_sink != e_sink || int'(bus.stim_mag) != e_mag)
                        phase_err++;
                    if (phase_n < 64) begin
                        ph_src[phase_n]  = bus.drive_src;
                        ph_sink[phase_n] = bus.drive_sink;
                        ph_mag[phase_n]  = bus.stim_mag;
                    end
                    phase_n++;
                    if (phase_n == stop_ph + 1) bus.stop_infinite = 1'b1;
                end
            end else if (bus.recovery_en != '0) begin
                if (!seen_rec) gap_before_rec = tail;
                seen_rec = 1;
                rec_n++;
                rec_val = bus.recovery_en;
                if (bus.drive_src != '0 || bus.drive_sink != '0 || bus.stim_mag != '0) rec_bad++;
            end else if (bus.busy) begin
                tail++;
            end
            if (c == abort_cyc) bus.abort = 1'b1;
            if (c == start_cyc) bus.start_finite = 1'b1;
            prev_en   = bus.stim_en;
            prev_src  = bus.drive_src;
            prev_sink = bus.drive_sink;
            if (bus.done) seen_done = 1;
            else if (seen_done) post++;
            if (post >= 2) break;
            @(negedge clk);
        end
        timed_out = seen_done ? 0 : 1;
        bus.stop_infinite = 1'b0;
        bus.abort         = 1'b0;
        bus.start_finite  = 1'b0;
    endtask

    initial begin
        bus.start_finite = 1'b0; bus.start_infinite = 1'b0;
        bus.stop_infinite = 1'b0; bus.abort = 1'b0;
        set_cfg(2, 3, 3, 12, 4, 4, 8, 50, 0, 0, 1, 1);
        repeat (2) @(negedge clk);
        check("rst_busy",    32'(bus.busy), 0);
        check("rst_stim_en", 32'(bus.stim_en), 0);
        check("rst_done",    32'(bus.done), 0);
        check("rst_src",     32'(bus.drive_src), 0);
        check("rst_sink",    32'(bus.drive_sink), 0);
        check("rst_rec",     32'(bus.recovery_en), 0);
        check("rst_mag",     32'(bus.stim_mag), 0);
        check("rst_train",   32'(bus.train_idx), 0);
        rstn = 1'b1;
        @(negedge clk);

        // Finite run, with a second start pulse while busy.
        start_run(1, 0);
        check("fin_first_phase", 32'(bus.stim_en), 1);
        watch(400, -1, -1, 5);
        check("fin_busy",    32'(busy_n), 192);
        check("fin_phases",  32'(phase_n), 32);
        check("fin_en",      32'(en_n), 64);
        check("fin_done",    32'(done_n), 1);
        check("fin_pol",     32'(phase_err), 0);
        check("fin_rec",     32'(rec_n), 8);
        check("fin_rec_val", 32'(rec_val), 32'h0FF0);
        check("fin_timeout", 32'(timed_out), 0);
        check("fin_idle",    32'(bus.busy), 0);

        // Ramp 30/60/90/100 per train.
        set_cfg(1, 0, 0, 1, 1, 4, 0, 100, 1, 30, 1, 1);
        start_run(1, 0);
        watch(100, -1, -1, -1);
        check("ramp_t0",   32'(ph_mag[0]), 30);
        check("ramp_t1",   32'(ph_mag[2]), 60);
        check("ramp_t2",   32'(ph_mag[4]), 90);
        check("ramp_t3a",  32'(ph_mag[6]), 100);
        check("ramp_t3b",  32'(ph_mag[7]), 100);
        check("ramp_busy", 32'(busy_n), 11);
        check("ramp_rec",  32'(rec_n), 0);
        check("ramp_pol",  32'(phase_err), 0);
        set_cfg(1, 0, 0, 1, 1, 4, 0, 100, 1, 0, 1, 1);
        start_run(1, 0);
        watch(100, -1, -1, -1);
        check("ramp0_first", 32'(ph_mag[0]), 100);
        check("ramp0_last",  32'(ph_mag[7]), 100);

        // Infinite run, stop during PHASE_A of bipulse 2.
        set_cfg(2, 3, 3, 12, 4, 0, 8, 50, 0, 0, 1, 1);
        start_run(0, 1);
        watch(400, 4, -1, -1);
        check("stop_phases", 32'(phase_n), 6);
        check("stop_rec",    32'(rec_n), 8);
        check("stop_nogap",  32'(gap_before_rec), 0);
        check("stop_busy",   32'(busy_n), 35);
        check("stop_done",   32'(done_n), 1);

        // Abort inside the first inter-train gap.
        set_cfg(2, 3, 3, 12, 4, 4, 8, 50, 0, 0, 1, 1);
        start_run(1, 0);
        watch(400, -1, 40, -1);
        check("abort_busy",    32'(busy_n), 49);
        check("abort_phases",  32'(phase_n), 8);
        check("abort_rec",     32'(rec_n), 8);
        check("abort_drive",   32'(rec_bad), 0);
        check("abort_rec_val", 32'(rec_val), 32'h0FF0);
        check("abort_done",    32'(done_n), 1);

        // Reset mid-PHASE_A, then a clean run.
        start_run(1, 0);
        check("rstmid_active", 32'(bus.stim_en), 1);
        #2 rstn = 1'b0;
        #1;
        check("rstmid_en",   32'(bus.stim_en), 0);
        check("rstmid_busy", 32'(bus.busy), 0);
        check("rstmid_src",  32'(bus.drive_src), 0);
        check("rstmid_mag",  32'(bus.stim_mag), 0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        start_run(1, 0);
        watch(400, -1, -1, -1);
        check("rstmid_rerun_busy", 32'(busy_n), 192);
        check("rstmid_rerun_done", 32'(done_n), 1);

        // Zero-length phases back-to-back, negative first, monopolar.
        set_cfg(0, 0, 0, 5, 2, 1, 2, 40, 0, 0, 0, 0);
        start_run(1, 0);
        watch(50, -1, -1, -1);
        check("l0_phases", 32'(phase_n), 4);
        check("l0_en",     32'(en_n), 4);
        check("l0_busy",   32'(busy_n), 6);
        check("l0_src0",   32'(ph_src[0]), 0);
        check("l0_sink0",  32'(ph_sink[0]), 32'(MP));
        check("l0_src1",   32'(ph_src[1]), 32'(MP));
        check("l0_pol",    32'(phase_err), 0);

        // Both starts together: finite run wins and terminates.
        set_cfg(1, 1, 0, 0, 1, 1, 1, 40, 0, 0, 1, 1);
        start_run(1, 1);
        watch(50, -1, -1, -1);
        check("both_busy",    32'(busy_n), 4);
        check("both_done",    32'(done_n), 1);
        check("both_timeout", 32'(timed_out), 0);

        // Zero bipulses: one busy cycle, done, nothing driven.
        set_cfg(2, 1, 1, 1, 0, 3, 4, 40, 0, 0, 1, 1);
        start_run(1, 0);
        watch(20, -1, -1, -1);
        check("nobp_busy", 32'(busy_n), 1);
        check("nobp_done", 32'(done_n), 1);
        check("nobp_en",   32'(en_n), 0);
        check("nobp_rec",  32'(rec_n), 0);

        $display("%0d/%0d checks passed", pass_n, chk_n);
        $finish;
    end
endmodule
